seq_mult_pk: RTL and testbench

- Parametrised iterative multiplier with its own controller. It is the next generation of the fixed 8-bit, 4-state partial-product multiplier control.
- Multiplies two WIDTH-bit operands by consuming STEP bits of op_b per cycle and accumulating shifted partial products.
- Supports unsigned and two's-complement modes, abort, and a done/result_ack handshake that holds the result.
- Sits between the operand-issuing sequencer and the result consumer in the arithmetic datapath.

---
 rtl/seq_mult_pk.sv | 103 ++++++++++
 tb/tb_seq_mult_pk.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seq_mult_pk.sv
// seq_mult_pk: iterative signed/unsigned multiplier consuming STEP multiplier bits per cycle
module seq_mult_pk #(
  parameter int WIDTH = 8,
  parameter int STEP = 4,
  localparam int N = WIDTH / STEP,
  localparam int CW = $clog2(N) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               abort,
  input  logic               result_ack,
  output logic               ack,
  output logic               locked,
  output logic               busy,
  output logic               done,
  output logic [CW-1:0]      count,
  output logic [2*WIDTH-1:0] product
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, CALC = 2'd2, FINISH = 2'd3;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, b_sh;
  logic sm_q, sm_d, neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod_q, prod_d, acc_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [STEP-1:0] digit;
  logic last;
  assign b_sh = b_q >> (STEP * cnt_q);
  assign digit = b_sh[STEP-1:0];
  assign acc_next = acc_q + (((2*WIDTH)'(a_q) * (2*WIDTH)'(digit)) << (STEP * cnt_q));
  assign last = cnt_q == CW'(N - 1);
  assign ack = state_q == LOAD;
  assign locked = state_q != IDLE;
  assign busy = state_q == LOAD || state_q == CALC;
  assign done = state_q == FINISH;
  assign count = cnt_q;
  assign product = prod_q;
  // Controller: capture in IDLE, take magnitudes in LOAD, accumulate partial products in CALC
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sm_d = sm_q;
    neg_d = neg_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    prod_d = prod_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = LOAD;
        a_d = op_a;
        b_d = op_b;
        sm_d = signed_mode;
      end
      LOAD: begin
        a_d = (sm_q && a_q[WIDTH-1]) ? -a_q : a_q;
        b_d = (sm_q && b_q[WIDTH-1]) ? -b_q : b_q;
        neg_d = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        acc_d = '0;
        cnt_d = '0;
        state_d = abort ? IDLE : CALC;
      end
      CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_q + 1'b1;
        if (abort) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (last) begin
          state_d = FINISH;
          cnt_d = '0;
          prod_d = neg_q ? -acc_next : acc_next;
        end
      end
      default: if (result_ack || abort) state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset clears everything so no partial result leaks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sm_q <= 1'b0;
      neg_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sm_q <= sm_d;
      neg_q <= neg_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      prod_q <= prod_d;
    end
  end
endmodule

// File: tb/tb_seq_mult_pk.sv
// tb_seq_mult_pk: scoreboard bench for 8x8 (STEP 4) and 16x16 (STEP 2) multiplier instances
module tb_seq_mult_pk;
  logic clk, rst;
  logic start8, sm8, abort8, result_ack8;
  logic [7:0] a8, b8;
  logic ack8, locked8, busy8, done8;
  logic [1:0] count8;
  logic [15:0] product8;
  logic start16, sm16, abort16, result_ack16;
  logic [15:0] a16, b16;
  logic ack16, locked16, busy16, done16;
  logic [3:0] count16;
  logic [31:0] product16;
  logic [31:0] q8[$], q16[$];
  logic done8_d, done16_d;
  int vecs, errs;

  seq_mult_pk #(.WIDTH(8), .STEP(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .op_a(a8), .op_b(b8),
    .abort(abort8), .result_ack(result_ack8), .ack(ack8), .locked(locked8), .busy(busy8),
    .done(done8), .count(count8), .product(product8));

  seq_mult_pk #(.WIDTH(16), .STEP(2)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16), .op_a(a16), .op_b(b16),
    .abort(abort16), .result_ack(result_ack16), .ack(ack16), .locked(locked16), .busy(busy16),
    .done(done16), .count(count16), .product(product16));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected product on the first cycle of each done
  always @(negedge clk) begin
    if (done8 && !done8_d) begin
      if (q8.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL w8 unexpected done: got %0h expected none", product8);
      end else check("w8 product", 32'(product8), q8.pop_front());
    end
    done8_d = done8;
  end

  always @(negedge clk) begin
    if (done16 && !done16_d) begin
      if (q16.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL w16 unexpected done: got %0h expected none", product16);
      end else check("w16 product", product16, q16.pop_front());
    end
    done16_d = done16;
  end

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int n;
    start8 = 1; sm8 = sm; a8 = a; b8 = b;
    q8.push_back(32'(exp));
    @(negedge clk); start8 = 0;
    check("w8 ack", ack8, 1);
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w8 latency", n, 4);
    result_ack8 = 1;
    @(negedge clk); result_ack8 = 0;
    check("w8 idle after ack", locked8, 0);
  endtask

  task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    int n;
    start16 = 1; sm16 = sm; a16 = a; b16 = b;
    q16.push_back(exp);
    @(negedge clk); start16 = 0;
    n = 1;
    while (!done16 && n < 40) begin
      @(negedge clk);
      n++;
      if (n >= 2 && n <= 9) check("w16 count", count16, n - 2);
    end
    check("w16 latency", n, 10);
    result_ack16 = 1;
    @(negedge clk); result_ack16 = 0;
    check("w16 idle after ack", locked16, 0);
  endtask

  initial begin
    vecs = 0; errs = 0; done8_d = 0; done16_d = 0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0; abort8 = 0; result_ack8 = 0;
    start16 = 0; sm16 = 0; a16 = 0; b16 = 0; abort16 = 0; result_ack16 = 0;
    rst = 1;
    #1;
    check("reset product", 32'(product8), 0);
    check("reset locked", locked8, 0);
    check("reset count", 32'(count8), 0);
    check("reset done", done8, 0);
    @(negedge clk); @(negedge clk); rst = 0;
    run8(0, 8'hFF, 8'hFF, 16'hFE01);
    run8(1, 8'h80, 8'h80, 16'h4000);
    run8(1, 8'hFD, 8'h05, 16'hFFF1);
    run8(1, 8'h7F, 8'hFF, 16'hFF81);
    run8(1, 8'h00, 8'hF9, 16'h0000);
    // start during CALC must not disturb the captured operands
    start8 = 1; sm8 = 0; a8 = 3; b8 = 4;
    q8.push_back(32'h000C);
    @(negedge clk); start8 = 0;
    @(negedge clk);
    check("calc busy", busy8, 1);
    start8 = 1; a8 = 9; b8 = 9;
    @(negedge clk); start8 = 0;
    check("no ack in calc", ack8, 0);
    @(negedge clk);
    check("finish done", done8, 1);
    repeat (5) begin
      @(negedge clk);
      check("hold done", done8, 1);
      check("hold product", 32'(product8), 32'h000C);
    end
    result_ack8 = 1; start8 = 1; a8 = 1; b8 = 1;
    @(negedge clk); result_ack8 = 0; start8 = 0;
    check("ack+start idle", locked8, 0);
    @(negedge clk);
    check("start dropped", locked8, 0);
    // abort and start together in IDLE: start ignored
    start8 = 1; abort8 = 1;
    @(negedge clk); start8 = 0; abort8 = 0;
    check("idle abort", locked8, 0);
    // abort on the final CALC step
    start8 = 1; a8 = 10; b8 = 10;
    @(negedge clk); start8 = 0;
    @(negedge clk);
    @(negedge clk);
    check("abort at count1", 32'(count8), 1);
    abort8 = 1;
    @(negedge clk); abort8 = 0;
    check("abort idle", locked8, 0);
    check("abort product kept", 32'(product8), 32'h000C);
    repeat (3) @(negedge clk);
    run8(0, 8'd10, 8'd10, 16'h0064);
    // asynchronous reset mid-CALC
    start8 = 1; a8 = 200; b8 = 200;
    @(negedge clk); start8 = 0;
    @(negedge clk);
    check("pre-reset busy", busy8, 1);
    #2 rst = 1;
    #1;
    check("async rst product", 32'(product8), 0);
    check("async rst locked", locked8, 0);
    check("async rst busy", busy8, 0);
    check("async rst count", 32'(count8), 0);
    @(negedge clk); rst = 0;
    run8(0, 8'd15, 8'd17, 16'h00FF);
    run16(0, 16'hFFFF, 16'h0002, 32'h0001FFFE);
    run16(1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);
    repeat (3) @(negedge clk);
    check("w8 queue drained", q8.size(), 0);
    check("w16 queue drained", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
